// File: rtl/toy_mem_pkg.sv
// Shared types, constants and sizing helpers for the toy memory arbiter.
package toy_mem_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_I = 2'd1,
      ARB_BUSY_D = 2'd2
   } arb_state_t;

   // Memory transfer direction
   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   // Counter width for a counter that must hold values 0..n-1 (at least 1 bit)
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/toy_mem_wdog.sv
// Watchdog: counts BUSY cycles without MREADY and flags when the abort point is reached.
module toy_mem_wdog
   import toy_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic CLK,
   input  logic RSTN,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned CW = cnt_w(TIMEOUT);

   logic [CW-1:0] cnt_q;

   // Wait counter: cleared when a transaction starts, advanced on each stalled cycle
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign expire_c = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/toy_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store traffic.
module toy_mem_arbiter
   import toy_mem_pkg::*;
#(
   parameter int unsigned AW         = 30,
   parameter int unsigned DW         = 32,
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          IREQ,
   input  logic [AW-1:0] IADDR,
   output logic          IGNT,
   output logic          IVALID,
   output logic [DW-1:0] IRDATA,
   input  logic          DREQ,
   input  logic          DRW,
   input  logic [AW-1:0] DADDR,
   input  logic [DW-1:0] DWDATA,
   output logic          DGNT,
   output logic          DVALID,
   output logic [DW-1:0] DRDATA,
   output logic          MREQ,
   output logic          MRW,
   output logic [AW-1:0] MADDR,
   output logic [DW-1:0] MWDATA,
   input  logic [DW-1:0] MRDATA,
   input  logic          MREADY,
   output logic          ERR
);

   localparam int unsigned SW = cnt_w(STARVE_LIM + 1);

   arb_state_t    state_q;
   arb_state_t    state_nxt;
   logic [SW-1:0] starve_q;
   logic          grant_i_c;
   logic          grant_d_c;
   logic          done_c;
   logic          abort_c;
   logic          wd_en_c;
   logic          wd_expire_c;

   toy_mem_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .clr      (grant_i_c | grant_d_c),
      .en       (wd_en_c),
      .expire_c (wd_expire_c)
   );

   // State register
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next state and per-edge strobes; D wins ties unless I-side has been starved
   always_comb begin
      state_nxt = state_q;
      grant_i_c = 1'b0;
      grant_d_c = 1'b0;
      done_c    = 1'b0;
      abort_c   = 1'b0;
      wd_en_c   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (DREQ && !(IREQ && (starve_q == SW'(STARVE_LIM)))) begin
               grant_d_c = 1'b1;
               state_nxt = ARB_BUSY_D;
            end else if (IREQ) begin
               grant_i_c = 1'b1;
               state_nxt = ARB_BUSY_I;
            end
         end
         ARB_BUSY_I, ARB_BUSY_D: begin
            if (MREADY) begin
               done_c    = 1'b1;
               state_nxt = ARB_IDLE;
            end else if (wd_expire_c) begin
               abort_c   = 1'b1;
               state_nxt = ARB_IDLE;
            end else begin
               wd_en_c = 1'b1;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // Registered outputs: memory request latches, grant/valid pulses, read data, starve counter
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         IGNT     <= 1'b0;
         DGNT     <= 1'b0;
         IVALID   <= 1'b0;
         DVALID   <= 1'b0;
         ERR      <= 1'b0;
         IRDATA   <= '0;
         DRDATA   <= '0;
         MREQ     <= 1'b0;
         MRW      <= RW_READ;
         MADDR    <= '0;
         MWDATA   <= '0;
         starve_q <= '0;
      end else begin
         IGNT   <= grant_i_c;
         DGNT   <= grant_d_c;
         IVALID <= (done_c | abort_c) && (state_q == ARB_BUSY_I);
         DVALID <= (done_c | abort_c) && (state_q == ARB_BUSY_D);
         ERR    <= abort_c;

         if (grant_i_c || grant_d_c) begin
            MREQ <= 1'b1;
         end else if (done_c || abort_c) begin
            MREQ <= 1'b0;
         end

         if (grant_d_c) begin
            MADDR  <= DADDR;
            MRW    <= DRW;
            MWDATA <= DWDATA;
         end else if (grant_i_c) begin
            MADDR <= IADDR;
            MRW   <= RW_READ;
         end

         if (done_c && (MRW == RW_READ)) begin
            if (state_q == ARB_BUSY_I) begin
               IRDATA <= MRDATA;
            end else begin
               DRDATA <= MRDATA;
            end
         end

         if (grant_i_c) begin
            starve_q <= '0;
         end else if (grant_d_c) begin
            if (!IREQ) begin
               starve_q <= '0;
            end else if (starve_q != SW'(STARVE_LIM)) begin
               starve_q <= starve_q + SW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// Self-checking bench for toy_mem_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_toy_mem_arbiter;

   localparam int unsigned AW         = 30;
   localparam int unsigned DW         = 32;
   localparam int unsigned TIMEOUT    = 16;
   localparam int unsigned STARVE_LIM = 4;

   logic          CLK = 1'b0;
   logic          RSTN = 1'b0;
   logic          IREQ = 1'b0;
   logic [AW-1:0] IADDR = '0;
   logic          IGNT, IVALID;
   logic [DW-1:0] IRDATA;
   logic          DREQ = 1'b0;
   logic          DRW = 1'b0;
   logic [AW-1:0] DADDR = '0;
   logic [DW-1:0] DWDATA = '0;
   logic          DGNT, DVALID;
   logic [DW-1:0] DRDATA;
   logic          MREQ, MRW;
   logic [AW-1:0] MADDR;
   logic [DW-1:0] MWDATA;
   logic [DW-1:0] MRDATA = '0;
   logic          MREADY = 1'b0;
   logic          ERR;

   always #5 CLK = ~CLK;

   toy_mem_arbiter #(
      .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .STARVE_LIM(STARVE_LIM)
   ) dut (
      .CLK(CLK), .RSTN(RSTN),
      .IREQ(IREQ), .IADDR(IADDR), .IGNT(IGNT), .IVALID(IVALID), .IRDATA(IRDATA),
      .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
      .DGNT(DGNT), .DVALID(DVALID), .DRDATA(DRDATA),
      .MREQ(MREQ), .MRW(MRW), .MADDR(MADDR), .MWDATA(MWDATA),
      .MRDATA(MRDATA), .MREADY(MREADY), .ERR(ERR)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: owner 0=none, 1=I-side, 2=D-side; age = BUSY cycles elapsed
   int            m_owner;
   int unsigned   m_age;
   int unsigned   m_starve;
   logic          m_mreq, m_mrw, m_ignt, m_dgnt, m_ival, m_dval, m_err;
   logic [AW-1:0] m_maddr;
   logic [DW-1:0] m_mwdata, m_irdata, m_drdata;

   task automatic model_reset();
      m_owner = 0; m_age = 0; m_starve = 0;
      m_mreq = 0; m_mrw = 0; m_ignt = 0; m_dgnt = 0; m_ival = 0; m_dval = 0; m_err = 0;
      m_maddr = '0; m_mwdata = '0; m_irdata = '0; m_drdata = '0;
   endtask

   task automatic model_edge();
      m_ignt = 0; m_dgnt = 0; m_ival = 0; m_dval = 0; m_err = 0;
      if (m_owner == 0) begin
         if (DREQ && !(IREQ && m_starve == STARVE_LIM)) begin
            m_owner = 2; m_dgnt = 1; m_mreq = 1; m_age = 0;
            m_maddr = DADDR; m_mrw = DRW; m_mwdata = DWDATA;
            if (!IREQ) m_starve = 0;
            else if (m_starve < STARVE_LIM) m_starve = m_starve + 1;
         end else if (IREQ) begin
            m_owner = 1; m_ignt = 1; m_mreq = 1; m_age = 0;
            m_maddr = IADDR; m_mrw = 1'b0; m_starve = 0;
         end
      end else begin
         m_age = m_age + 1;
         if (MREADY || m_age == TIMEOUT) begin
            if (m_owner == 1) m_ival = 1; else m_dval = 1;
            if (MREADY) begin
               if (!m_mrw) begin
                  if (m_owner == 1) m_irdata = MRDATA; else m_drdata = MRDATA;
               end
            end else begin
               m_err = 1;
            end
            m_owner = 0; m_mreq = 0;
         end
      end
   endtask

   task automatic compare_all();
      check_val("IGNT",   64'(IGNT),   64'(m_ignt));
      check_val("DGNT",   64'(DGNT),   64'(m_dgnt));
      check_val("IVALID", 64'(IVALID), 64'(m_ival));
      check_val("DVALID", 64'(DVALID), 64'(m_dval));
      check_val("ERR",    64'(ERR),    64'(m_err));
      check_val("MREQ",   64'(MREQ),   64'(m_mreq));
      check_val("MRW",    64'(MRW),    64'(m_mrw));
      check_val("MADDR",  64'(MADDR),  64'(m_maddr));
      check_val("MWDATA", 64'(MWDATA), 64'(m_mwdata));
      check_val("IRDATA", 64'(IRDATA), 64'(m_irdata));
      check_val("DRDATA", 64'(DRDATA), 64'(m_drdata));
   endtask

   // One clock: advance the model with the inputs held before the edge, then compare
   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      int n;
      logic [6:0] grants;
      logic hang;

      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      compare_all();
      RSTN = 1'b1;

      // Zero-wait fetch
      IREQ = 1; IADDR = AW'(32'h10); MREADY = 1; MRDATA = 32'hDEADBEEF;
      tick();
      check_val("t1_ignt", 64'(IGNT), 64'd1);
      check_val("t1_maddr", 64'(MADDR), 64'h10);
      check_val("t1_mrw", 64'(MRW), 64'd0);
      IREQ = 0;
      tick();
      check_val("t1_ivalid", 64'(IVALID), 64'd1);
      check_val("t1_irdata", 64'(IRDATA), 64'hDEADBEEF);

      // Simultaneous requests: D write first, then I
      IREQ = 1; DREQ = 1; DRW = 1; DADDR = AW'(32'h20); DWDATA = 32'h12345678; MRDATA = 32'hCAFEF00D;
      tick();
      check_val("t2_dgnt", 64'(DGNT), 64'd1);
      check_val("t2_ignt", 64'(IGNT), 64'd0);
      check_val("t2_mrw", 64'(MRW), 64'd1);
      check_val("t2_mwdata", 64'(MWDATA), 64'h12345678);
      DREQ = 0;
      tick();
      check_val("t2_dvalid", 64'(DVALID), 64'd1);
      check_val("t2_drdata", 64'(DRDATA), 64'd0);
      tick();
      check_val("t2_ignt_next", 64'(IGNT), 64'd1);
      IREQ = 0;
      tick();

      // Starvation: both held, D reads, zero-wait memory
      IREQ = 1; DREQ = 1; DRW = 0; MREADY = 1;
      n = 0; grants = '0;
      for (int i = 0; i < 14; i++) begin
         MRDATA = $urandom;
         tick();
         if (IGNT || DGNT) begin
            if (n < 7) grants = {grants[5:0], IGNT};
            n++;
         end
      end
      check_val("t3_grant_order", 64'(grants), 64'(7'b0000100));
      IREQ = 0; DREQ = 0;
      repeat (2) tick();

      // D read with three wait cycles
      DREQ = 1; DRW = 0; DADDR = AW'(32'h33); MREADY = 0; MRDATA = 32'h0BADC0DE;
      tick();
      DREQ = 0;
      repeat (3) tick();
      check_val("t4_mreq", 64'(MREQ), 64'd1);
      check_val("t4_maddr", 64'(MADDR), 64'h33);
      MREADY = 1;
      tick();
      check_val("t4_dvalid", 64'(DVALID), 64'd1);
      check_val("t4_err", 64'(ERR), 64'd0);
      check_val("t4_drdata", 64'(DRDATA), 64'h0BADC0DE);
      MREADY = 0;
      tick();

      // Hung memory: watchdog abort
      DREQ = 1; DRW = 0; DADDR = AW'(32'h44);
      tick();
      DREQ = 0;
      n = 1;
      while (MREQ && n < 40) begin
         tick();
         if (MREQ) n++;
      end
      check_val("t5_busy_cycles", 64'(n), 64'(TIMEOUT));
      check_val("t5_dvalid", 64'(DVALID), 64'd1);
      check_val("t5_err", 64'(ERR), 64'd1);
      IREQ = 1; IADDR = AW'(32'h55);
      tick();
      check_val("t5_next_ignt", 64'(IGNT), 64'd1);
      IREQ = 0; MREADY = 1;
      tick();
      MREADY = 0;
      tick();

      // Reset during BUSY_D grant cycle
      DREQ = 1; DRW = 0; DADDR = AW'(32'h66);
      tick();
      DREQ = 0;
      RSTN = 0;
      #1;
      check_val("t6_mreq", 64'(MREQ), 64'd0);
      check_val("t6_dgnt", 64'(DGNT), 64'd0);
      check_val("t6_dvalid", 64'(DVALID), 64'd0);
      model_reset();
      @(posedge CLK);
      #1;
      RSTN = 1;
      compare_all();
      MREADY = 1;
      repeat (3) tick();

      // Randomized traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         hang = ((cyc / 40) % 4) == 3;
         if (IGNT || !IREQ) begin
            IREQ = ($urandom_range(0, 2) != 0);
            IADDR = AW'($urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            IREQ = 0;
         end
         if (DGNT || !DREQ) begin
            DREQ = ($urandom_range(0, 2) != 0);
            DRW = 1'($urandom_range(0, 1));
            DADDR = AW'($urandom);
            DWDATA = $urandom;
         end else if ($urandom_range(0, 15) == 0) begin
            DREQ = 0;
         end
         MREADY = hang ? 1'b0 : ($urandom_range(0, 2) == 0);
         MRDATA = $urandom;
         tick();
         check_val("excl_valid", 64'(IVALID & DVALID), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
